// File: rtl/teclado_pkg.sv
// Shared types and tables for the 4x4 keypad scanner.
//   estado_t      : scanner FSM states
//   COL_IDLE      : column drive with column 0 active
//   codigo_tecla  : key-code table indexed by {row, col}
//   drive_columna : active-low one-hot column drive for a column index
//   fila_ganadora : lowest-index low row of a row vector
package teclado_pkg;

    typedef enum logic [1:0] {
        ESCANEO    = 2'd0,
        DEBOUNCE   = 2'd1,
        PRESIONADA = 2'd2
    } estado_t;

    localparam logic [3:0] COL_IDLE = 4'b1110;

    // Keypad legend: row 3 carries * -> E and # -> F.
    function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
        logic [3:0] codigo;
        codigo = 4'h0;
        case ({fila, col})
            4'h0: codigo = 4'h1;
            4'h1: codigo = 4'h2;
            4'h2: codigo = 4'h3;
            4'h3: codigo = 4'hA;
            4'h4: codigo = 4'h4;
            4'h5: codigo = 4'h5;
            4'h6: codigo = 4'h6;
            4'h7: codigo = 4'hB;
            4'h8: codigo = 4'h7;
            4'h9: codigo = 4'h8;
            4'hA: codigo = 4'h9;
            4'hB: codigo = 4'hC;
            4'hC: codigo = 4'hE;
            4'hD: codigo = 4'h0;
            4'hE: codigo = 4'hF;
            4'hF: codigo = 4'hD;
        endcase
        return codigo;
    endfunction

    function automatic logic [3:0] drive_columna(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

    function automatic logic [1:0] fila_ganadora(input logic [3:0] filas);
        logic [1:0] fila;
        fila = 2'd3;
        if (!filas[2]) fila = 2'd2;
        if (!filas[1]) fila = 2'd1;
        if (!filas[0]) fila = 2'd0;
        return fila;
    endfunction

endpackage

// File: rtl/escaner_teclado_4x4_if.sv
// Key-report bus of the keypad scanner.
//   o_Tecla      : code of the last accepted key
//   o_Valida     : one-cycle strobe on a new accept
//   o_Presionada : key held (accept until release accepted)
// master = scanner side, slave = consumer side.
interface escaner_teclado_4x4_if;
    logic [3:0] o_Tecla;
    logic       o_Valida;
    logic       o_Presionada;

    modport master (output o_Tecla, output o_Valida, output o_Presionada);
    modport slave  (input  o_Tecla, input  o_Valida, input  o_Presionada);
endinterface

// File: rtl/generador_tick.sv
// Prescaler producing a one-cycle tick every SCAN_DIV clocks.
//   i_Clk  : clock
//   i_Rst  : synchronous active-low reset
//   o_Tick : high while the count is SCAN_DIV-1
module generador_tick #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic i_Clk,
    input  logic i_Rst,
    output logic o_Tick
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign o_Tick = (cnt == CNT_MAX);

    // Counts 0..SCAN_DIV-1 and wraps on the tick cycle.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst)      cnt <= '0;
        else if (o_Tick) cnt <= '0;
        else             cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/escaner_teclado_4x4.sv
// 4x4 matrix keypad scanner with debounce.
//   i_Clk      : clock
//   i_Rst      : synchronous active-low reset
//   i_Filas    : keypad rows, active-low, asynchronous
//   o_Columnas : column drive, exactly one bit low
//   bus        : key report (o_Tecla, o_Valida, o_Presionada)
module escaner_teclado_4x4
    import teclado_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEBOUNCE_N = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic [3:0]                  i_Filas,
    output logic [3:0]                  o_Columnas,
    escaner_teclado_4x4_if.master       bus
);
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_N + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_N);

    logic             tick;
    logic [3:0]       filas_meta;
    logic [3:0]       filas_sync;

    estado_t          estado, estado_nxt;
    logic [1:0]       col, col_nxt;
    logic [1:0]       fila_r, fila_nxt;
    logic [DEB_W-1:0] cnt, cnt_nxt;
    logic [3:0]       tecla_nxt;
    logic             valida_nxt;
    logic             presionada_nxt;

    logic             sin_tecla;
    logic [1:0]       ganadora;
    logic [DEB_W-1:0] cnt_inc;
    logic             aceptar;

    generador_tick #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .o_Tick (tick)
    );

    // Row synchronizer, then state and registered outputs.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            filas_meta       <= 4'hF;
            filas_sync       <= 4'hF;
            estado           <= ESCANEO;
            col              <= 2'd0;
            fila_r           <= 2'd0;
            cnt              <= '0;
            o_Columnas       <= COL_IDLE;
            bus.o_Tecla      <= 4'h0;
            bus.o_Valida     <= 1'b0;
            bus.o_Presionada <= 1'b0;
        end else begin
            filas_meta       <= i_Filas;
            filas_sync       <= filas_meta;
            estado           <= estado_nxt;
            col              <= col_nxt;
            fila_r           <= fila_nxt;
            cnt              <= cnt_nxt;
            o_Columnas       <= drive_columna(col_nxt);
            bus.o_Tecla      <= tecla_nxt;
            bus.o_Valida     <= valida_nxt;
            bus.o_Presionada <= presionada_nxt;
        end
    end

    // Next-state logic; every action is gated by the scan tick.
    always_comb begin
        estado_nxt     = estado;
        col_nxt        = col;
        fila_nxt       = fila_r;
        cnt_nxt        = cnt;
        tecla_nxt      = bus.o_Tecla;
        valida_nxt     = 1'b0;
        presionada_nxt = bus.o_Presionada;
        aceptar        = 1'b0;
        sin_tecla      = (filas_sync == 4'hF);
        ganadora       = fila_ganadora(filas_sync);
        cnt_inc        = cnt + DEB_W'(1);

        if (tick) begin
            case (estado)
                ESCANEO: begin
                    if (sin_tecla) begin
                        col_nxt = col + 2'd1;
                    end else begin
                        fila_nxt = ganadora;
                        cnt_nxt  = DEB_W'(1);
                        // A single-tick debounce accepts on the detection tick.
                        if (DEB_MAX == DEB_W'(1)) aceptar = 1'b1;
                        else                      estado_nxt = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!sin_tecla && ganadora == fila_r) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == DEB_MAX) aceptar = 1'b1;
                    end else begin
                        estado_nxt = ESCANEO;
                        col_nxt    = col + 2'd1;
                    end
                end
                PRESIONADA: begin
                    // Release counter; any low row restarts it, extra keys are ignored.
                    if (sin_tecla) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == DEB_MAX) begin
                            cnt_nxt        = '0;
                            presionada_nxt = 1'b0;
                            col_nxt        = col + 2'd1;
                            estado_nxt     = ESCANEO;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    estado_nxt = ESCANEO;
                    cnt_nxt    = '0;
                end
            endcase

            if (aceptar) begin
                tecla_nxt      = codigo_tecla(ganadora, col);
                valida_nxt     = 1'b1;
                presionada_nxt = 1'b1;
                cnt_nxt        = '0;
                estado_nxt     = PRESIONADA;
            end
        end
    end
endmodule
